// File: rtl/compare_encoded_fifo.sv
// Compares the freshly encoded codeword against the copy read back from disk, then queues
// the stripe together with its compare result. Equal stripes can be dropped on request.
module compare_encoded_fifo #(
   parameter int CW_W   = 12,
   parameter int N_DATA = 2,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4,
   localparam int DC_W  = $clog2(CW_W + 1),
   localparam int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CW_W-1:0]          enc_data,
   input  logic [CW_W-1:0]          enc_data_old,
   input  logic [N_DATA*CW_W-1:0]   data_enc_in,
   input  logic [CW_W-1:0]          parity_in,
   input  logic [ADDR_W-1:0]        address_in,
   input  logic                     skip_equal,
   input  logic                     clear_stats,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N_DATA*CW_W-1:0]   data_enc_out,
   output logic [CW_W-1:0]          parity_out,
   output logic [ADDR_W-1:0]        address_out,
   output logic                     equal,
   output logic [DC_W-1:0]          diff_count,
   output logic [CNT_W-1:0]         equal_cnt,
   output logic [CNT_W-1:0]         mismatch_cnt,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [N_DATA*CW_W-1:0] data;
      logic [CW_W-1:0]        parity;
      logic [ADDR_W-1:0]      addr;
      logic                   eq;
      logic [DC_W-1:0]        dc;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           new_entry;
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [CNT_W-1:0] equal_cnt_q;
   logic [CNT_W-1:0] mismatch_cnt_q;
   logic [CNT_W-1:0] drop_cnt_q;
   logic [CW_W-1:0]  diff_bits;
   logic             eq_now;
   logic [DC_W-1:0]  dc_now;
   logic             accept;
   logic             push;
   logic             pop;

   always_comb begin
      diff_bits = enc_data ^ enc_data_old;
      eq_now    = (diff_bits == '0);
      dc_now    = '0;
      for (int i = 0; i < CW_W; i++)
         dc_now = dc_now + DC_W'(diff_bits[i]);
   end

   // Ready ignores out_ready so a full queue never accepts on the same edge it pops.
   assign in_ready  = !reset && (count < (PTR_W+1)'(DEPTH));
   assign out_valid = !reset && (count != '0);
   assign accept    = in_valid && in_ready;
   assign push      = accept && !(skip_equal && eq_now);
   assign pop       = out_valid && out_ready;

   assign new_entry = '{data: data_enc_in, parity: parity_in, addr: address_in,
                        eq: eq_now, dc: dc_now};
   assign head      = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= new_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Statistics see every accept, including dropped ones; a clear overrides counting.
   always_ff @(posedge clk) begin
      if (reset || clear_stats) begin
         equal_cnt_q    <= '0;
         mismatch_cnt_q <= '0;
         drop_cnt_q     <= '0;
      end else if (accept) begin
         if (eq_now && equal_cnt_q != CNT_MAX)
            equal_cnt_q <= equal_cnt_q + CNT_W'(1);
         if (!eq_now && mismatch_cnt_q != CNT_MAX)
            mismatch_cnt_q <= mismatch_cnt_q + CNT_W'(1);
         if (eq_now && skip_equal && drop_cnt_q != CNT_MAX)
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      data_enc_out = '0;
      parity_out   = '0;
      address_out  = '0;
      equal        = 1'b0;
      diff_count   = '0;
      if (out_valid) begin
         data_enc_out = head.data;
         parity_out   = head.parity;
         address_out  = head.addr;
         equal        = head.eq;
         diff_count   = head.dc;
      end
   end

   assign equal_cnt    = reset ? '0 : equal_cnt_q;
   assign mismatch_cnt = reset ? '0 : mismatch_cnt_q;
   assign drop_cnt     = reset ? '0 : drop_cnt_q;

endmodule
